orv64_itb_dump_reader: RTL and testbench

//  Read-side engine for the ORV64 instruction trace buffer (ITB) RAM. On start, walks the RAM through the debug access port, oldest entry first.

---
 rtl/orv64_itb_dump_reader_if.sv | 31 +++
 rtl/orv64_itb_dump_reader.sv | 177 +++++++++++++++++
 tb/tb_orv64_itb_dump_reader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/orv64_itb_dump_reader_if.sv
// Bus bundle for the ITB dump reader: trace-RAM debug access port plus the
// valid/ready entry stream toward the debug unit.
interface orv64_itb_dump_reader_if #(
  parameter int ITB_AW = 4,
  parameter int ITB_DW = 39
);
  logic              itb_en;
  logic              itb_rw;
  logic [ITB_AW-1:0] itb_addr;
  logic [ITB_DW-1:0] itb_din;
  logic [ITB_DW-1:0] itb_dout;
  logic              out_valid;
  logic              out_ready;
  logic [ITB_DW-1:0] out_data;
  logic [ITB_AW:0]   out_idx;
  logic              out_last;

  modport master (
    output itb_en, itb_rw, itb_addr, itb_din,
    input  itb_dout,
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  itb_en, itb_rw, itb_addr, itb_din,
    output itb_dout,
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/orv64_itb_dump_reader.sv
// ORV64 ITB dump reader: walks the trace RAM oldest-first and streams entries out.
// ORV64_ITB_DUMP_CLEAR_EN enables clear-on-read (each read followed by a zero write).
module orv64_itb_dump_reader #(
  parameter int ITB_AW = 4,
  parameter int ITB_DW = 39
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ITB_AW-1:0]       last_ptr,
  input  logic                    buf_wrapped,
  input  logic                    buf_empty,
  output logic                    busy,
  output logic                    done,
  orv64_itb_dump_reader_if.master bus
);
  localparam int CW = ITB_AW + 1;
  localparam logic [ITB_AW-1:0] ONE_A = 1;
  localparam logic [CW-1:0]     ONE_C = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_DRAIN, ST_DONE} state_e;

  state_e                 state_q, state_d;
  logic [ITB_AW-1:0]      base_q, base_d;
  logic [CW-1:0]          total_q, total_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic [CW-1:0]          inflight_idx_q, inflight_idx_d;
  logic [1:0][ITB_DW-1:0] fifo_data_q, fifo_data_d;
  logic [1:0][CW-1:0]     fifo_idx_q, fifo_idx_d;
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic                   pop, issue, wr_blk;
  logic [2:0]             occ;
  logic [ITB_AW-1:0]      rd_addr;

  assign rd_addr = base_q + issued_q[ITB_AW-1:0];

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    total_d         = total_q;
    issued_d        = issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = inflight_last_q;
    inflight_idx_d  = inflight_idx_q;
    fifo_data_d     = fifo_data_q;
    fifo_idx_d      = fifo_idx_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;

    // Occupancy counts the slot freed by this cycle's pop so a full-rate stream never bubbles
    pop   = (fifo_cnt_q != 2'd0) && bus.out_ready;
    occ   = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue = (state_q == ST_RD) && (issued_q != total_q) && (occ < 3'd2) && !wr_blk;

    if (issue) begin
      issued_d        = issued_q + ONE_C;
      inflight_d      = 1'b1;
      inflight_idx_d  = issued_q;
      inflight_last_d = (issued_q == total_q - ONE_C);
    end
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = bus.itb_dout;
      fifo_idx_d[wr_ptr_q]  = inflight_idx_q;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_RD;
        issued_d = '0;
        base_d   = '0;
        if (buf_wrapped) begin
          base_d  = last_ptr + ONE_A;
          total_d = {1'b1, {ITB_AW{1'b0}}};
        end else if (buf_empty) begin
          total_d = '0;
        end else begin
          total_d = {1'b0, last_ptr} + ONE_C;
        end
      end
      ST_RD:    if (issued_q == total_q) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_d && fifo_cnt_d == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A read already on the RAM port still completes, but its data is dropped
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      inflight_d = 1'b0;
      fifo_cnt_d = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      total_q         <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_idx_q  <= '0;
      fifo_data_q     <= '0;
      fifo_idx_q      <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      total_q         <= total_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      inflight_idx_q  <= inflight_idx_d;
      fifo_data_q     <= fifo_data_d;
      fifo_idx_q      <= fifo_idx_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

`ifdef ORV64_ITB_DUMP_CLEAR_EN
  logic              wr_pend_q, wr_pend_d;
  logic [ITB_AW-1:0] wr_addr_q, wr_addr_d;

  // The zero write is committed once its read issues; abort does not cancel it
  always_comb begin
    wr_pend_d = issue;
    wr_addr_d = issue ? rd_addr : wr_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_blk       = wr_pend_q;
  assign bus.itb_en   = issue | wr_pend_q;
  assign bus.itb_rw   = wr_pend_q;
  assign bus.itb_addr = wr_pend_q ? wr_addr_q : (issue ? rd_addr : '0);
`else
  assign wr_blk       = 1'b0;
  assign bus.itb_en   = issue;
  assign bus.itb_rw   = 1'b0;
  assign bus.itb_addr = issue ? rd_addr : '0;
`endif
  assign bus.itb_din  = '0;

  assign bus.out_valid = (fifo_cnt_q != 2'd0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_idx   = fifo_idx_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q];
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
endmodule

// File: tb/tb_orv64_itb_dump_reader.sv
// Bench for orv64_itb_dump_reader: RAM model plus a scoreboard of expected
// read addresses and output entries, checked by a negedge monitor.
module tb_orv64_itb_dump_reader;
  localparam int AW = 4;
  localparam int DW = 39;
  localparam int D  = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW:0]   idx;
    logic          last;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, buf_wrapped, buf_empty, busy, done;
  logic [AW-1:0] last_ptr;
  logic          restore_req = 1'b0;

  orv64_itb_dump_reader_if #(.ITB_AW(AW), .ITB_DW(DW)) bus ();

  orv64_itb_dump_reader #(.ITB_AW(AW), .ITB_DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .last_ptr(last_ptr),
    .buf_wrapped(buf_wrapped), .buf_empty(buf_empty), .busy(busy), .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [D];
  logic [DW-1:0] gold [D];
  ent_t          exp_q [$];
  logic [AW-1:0] exp_addr_q [$];
  int checks = 0, errors = 0, cyc = 0, pop_cnt = 0, done_cnt = 0, done_cyc = 0;
  int last_pop_cyc = 0, wr_cnt = 0, en_run = 0, max_run = 0, occ = 0;

  // RAM model: one-cycle read latency, writes land at the edge
  initial forever begin
    @(posedge clk);
    if (restore_req) for (int i = 0; i < D; i++) mem[i] <= gold[i];
    else if (bus.itb_en) begin
      if (bus.itb_rw) mem[bus.itb_addr] <= bus.itb_din;
      else bus.itb_dout <= mem[bus.itb_addr];
    end
  end

  // Monitor: address order, entry scoreboard, stall hold, occupancy, done
  initial begin
    logic          prev_stall, prev_rd;
    logic [AW-1:0] prev_rd_addr, ea;
    ent_t          got, prev_ent, e;
    prev_stall = 1'b0; prev_rd = 1'b0; prev_rd_addr = '0; prev_ent = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        occ = 0; prev_stall = 1'b0; prev_rd = 1'b0; en_run = 0;
      end else begin
        got = {bus.out_data, bus.out_idx, bus.out_last};
        if (bus.itb_en && !bus.itb_rw) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++; $display("FAIL rd_addr: read of addr %0d, required no read", bus.itb_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (bus.itb_addr !== ea) begin
              errors++; $display("FAIL rd_addr: got %0d, required %0d", bus.itb_addr, ea);
            end
          end
          occ++;
        end
        if (bus.itb_en && bus.itb_rw) begin
          wr_cnt++;
`ifdef ORV64_ITB_DUMP_CLEAR_EN
          checks++;
          if (!prev_rd || bus.itb_addr !== prev_rd_addr || bus.itb_din !== '0) begin
            errors++;
            $display("FAIL clear_wr: wr addr %0d din %0h, required addr %0d din 0 after read",
                     bus.itb_addr, bus.itb_din, prev_rd_addr);
          end
`endif
        end
        prev_rd      = bus.itb_en && !bus.itb_rw;
        prev_rd_addr = bus.itb_addr;
        en_run       = bus.itb_en ? en_run + 1 : 0;
        if (en_run > max_run) max_run = en_run;
        if (prev_stall && busy) begin
          checks++;
          if (!bus.out_valid || got !== prev_ent) begin
            errors++; $display("FAIL stall_hold: valid %0b entry %h, required 1 %h", bus.out_valid, got, prev_ent);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL pop: got entry %h, required no output", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++; $display("FAIL pop: got data %h idx %0d last %0b, required data %h idx %0d last %0b",
                                 bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
            end
          end
          occ--; pop_cnt++; last_pop_cyc = cyc;
        end
        if (bus.itb_en && !bus.itb_rw) begin
          checks++;
          if (occ > 2) begin errors++; $display("FAIL occupancy: got %0d, required <= 2", occ); end
        end
        if (!busy) occ = 0;
        if (done) begin done_cnt++; done_cyc = cyc; end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_ent   = got;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // Sets up the dump, fills the scoreboard from the golden image (or zeros), pulses start
  task automatic start_dump(input int lp, input bit wr, input bit em, input bit zero);
    int total, base, a;
    logic [DW-1:0] d;
    if (!zero) begin
      restore_req = 1'b1; @(posedge clk); #1; restore_req = 1'b0;
    end
    total = wr ? D : (em ? 0 : lp + 1);
    base  = wr ? (lp + 1) % D : 0;
    for (int i = 0; i < total; i++) begin
      a = (base + i) % D;
      d = zero ? '0 : gold[a];
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back({d, (AW+1)'(i), i == total - 1});
    end
    last_ptr = AW'(lp); buf_wrapped = wr; buf_empty = em;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
    checks++; if ({bus.itb_en, bus.itb_rw, bus.itb_addr} !== '0) begin
      errors++; $display("FAIL reset_ram_port: got %b, required 0", {bus.itb_en, bus.itb_rw, bus.itb_addr});
    end
    checks++; if ({bus.out_data, bus.out_idx, bus.out_last, bus.itb_din} !== '0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", {bus.out_data, bus.out_idx, bus.out_last});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_t1_linear;
    int d0; bit ok;
    bus.out_ready = 1'b1; pop_cnt = 0; d0 = done_cnt;
    start_dump(4, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: got no done, required done"); end
    checks++; if (pop_cnt != 5) begin errors++; $display("FAIL t1_count: got %0d, required 5", pop_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t1_left: got %0d, required 0", exp_q.size()); end
    checks++; if (done_cyc != last_pop_cyc + 1) begin
      errors++; $display("FAIL t1_done_time: got %0d, required %0d", done_cyc, last_pop_cyc + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL t1_done_pulse: got %0d, required %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_t2_wrapped;
    int d0; bit ok;
    bus.out_ready = 1'b1; pop_cnt = 0; d0 = done_cnt; max_run = 0;
    start_dump(5, 1, 0, 0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t2_timeout: got no done, required done"); end
    checks++; if (pop_cnt != 16) begin errors++; $display("FAIL t2_count: got %0d, required 16", pop_cnt); end
    checks++; if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++; $display("FAIL t2_left: got %0d, required 0", exp_q.size() + exp_addr_q.size());
    end
`ifdef ORV64_ITB_DUMP_CLEAR_EN
    checks++; if (max_run != 32) begin errors++; $display("FAIL t2_en_run: got %0d, required 32", max_run); end
`else
    checks++; if (max_run != 16) begin errors++; $display("FAIL t2_en_run: got %0d, required 16", max_run); end
`endif
  endtask

  task automatic test_t3_empty;
    int d0;
    d0 = done_cnt; max_run = 0;
    start_dump(7, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      checks++; if (busy !== (k <= 3)) begin errors++; $display("FAIL t3_busy[%0d]: got %b, required %b", k, busy, k <= 3); end
      checks++; if (done !== (k == 3)) begin errors++; $display("FAIL t3_done[%0d]: got %b, required %b", k, done, k == 3); end
      @(posedge clk); #1;
    end
    checks++; if (max_run != 0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL t3_activity: got en_run %0d dones %0d, required 0 and 1", max_run, done_cnt - d0);
    end
  endtask

  task automatic test_t4_backpressure;
    int d0; bit ok;
    pop_cnt = 0; d0 = done_cnt;
    start_dump(5, 1, 0, 0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = (i % 3 == 0);
      // A start while busy, with different inputs, must not disturb the dump
      if (i == 7) begin start = 1'b1; last_ptr = '0; buf_wrapped = 1'b0; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    start = 1'b0; bus.out_ready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL t4_timeout: got no done, required done"); end
    checks++; if (pop_cnt != 16) begin errors++; $display("FAIL t4_count: got %0d, required 16", pop_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t4_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_t5_abort(input bit use_rst);
    int d0; bit ok;
    bus.out_ready = 1'b1; pop_cnt = 0; d0 = done_cnt;
    start_dump(5, 1, 0, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pop_cnt >= 3) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t5_pops: got %0d, required 3", pop_cnt); end
    if (use_rst) rst = 1'b1;
    else begin abort = 1'b1; start = 1'b1; end
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b, required 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b, required 0", busy); end
    exp_q.delete(); exp_addr_q.delete();
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle: got busy %b, required 0", busy); end
    end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL t5_no_done: got %0d, required 0", done_cnt - d0); end
    pop_cnt = 0; d0 = done_cnt;
    start_dump(5, 1, 0, 0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    checks++; if (!ok || pop_cnt != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL t5_redump: got done %0b pops %0d left %0d, required 1 16 0", ok, pop_cnt, exp_q.size());
    end
  endtask

`ifdef ORV64_ITB_DUMP_CLEAR_EN
  task automatic test_t6_clear;
    int w0; bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      bus.out_ready = 1'b1; pop_cnt = 0; w0 = wr_cnt;
      start_dump(4, 0, 0, pass == 1);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (!busy) begin ok = 1; break; end
      end
      checks++; if (!ok || pop_cnt != 5) begin errors++; $display("FAIL t6_count[%0d]: got %0d, required 5", pass, pop_cnt); end
      checks++; if (wr_cnt - w0 != 5) begin errors++; $display("FAIL t6_writes[%0d]: got %0d, required 5", pass, wr_cnt - w0); end
    end
  endtask
`else
  task automatic test_no_write;
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL no_write: got %0d writes, required 0", wr_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < D; i++) begin
      gold[i] = DW'({$urandom(), $urandom()});
      mem[i]  = gold[i];
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; last_ptr = '0;
    buf_wrapped = 1'b0; buf_empty = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_t1_linear();
    test_t2_wrapped();
    test_t3_empty();
    test_t4_backpressure();
    test_t5_abort(1'b0);
    test_t5_abort(1'b1);
`ifdef ORV64_ITB_DUMP_CLEAR_EN
    test_t6_clear();
`else
    test_no_write();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
